adc_receiver: RTL

// - Return path of the Ising loop: takes 256-bit ADC words (16 lanes x 16b signed), sums the GPIO-selected lanes over a

---
 rtl/adc_receiver.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_receiver.sv
// ADC return path of the Ising loop.
// Each window of num_acc valid ADC words is reduced to one result. The result is the sum of the
// enabled 16-bit signed lanes over every word in the window, minus an offset, arithmetic-shifted
// right and saturated to NUM_BITS. Configuration arrives over the shared GPIO write bus.
//
// Handshake: there is no back-pressure in either direction. adc_valid qualifies adc_in in the
// cycle it is high; a word with adc_valid=0 is simply not counted. fsm_out_valid is a one-cycle
// pulse qualifying fsm_val_out, and the consumer must take the value in that cycle.
// fsm_val_out keeps the last result between pulses.
module adc_receiver #(
  parameter logic [15:0] ADDR_LANE_MASK = 16'd0,
  parameter logic [15:0] ADDR_NUM_ACC   = 16'd1,
  parameter logic [15:0] ADDR_SHIFT     = 16'd2,
  parameter logic [15:0] ADDR_OFFSET    = 16'd3,
  parameter logic [15:0] ADDR_MODE      = 16'd4,
  parameter int          NUM_BITS       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_in,
  input  logic [255:0]        adc_in,
  input  logic                adc_valid,
  input  logic                del_trig,
  output logic [NUM_BITS-1:0] fsm_val_out,
  output logic                fsm_out_valid
);

  localparam int SAT_MAX = (1 << (NUM_BITS - 1)) - 1;
  localparam int SAT_MIN = -(1 << (NUM_BITS - 1));

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------------------------
  // GPIO write port
  // ---------------------------------------------------------------------------------------------
  logic        w_s1, w_s2, w_s3;
  logic        w_edge;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        unused_gpio;

  assign wr_addr     = gpio_in[15:0];
  assign wr_data     = gpio_in[23:16];
  assign w_edge      = w_s2 & ~w_s3;
  assign unused_gpio = ^gpio_in[31:25];

  // Bring the asynchronous write strobe into clk domain and keep one extra stage for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_s1 <= 1'b0;
      w_s2 <= 1'b0;
      w_s3 <= 1'b0;
    end else begin
      w_s1 <= gpio_in[24];
      w_s2 <= w_s1;
      w_s3 <= w_s2;
    end
  end

  // Live configuration registers; 16-bit ones are loaded as two byte writes, LSB first.
  logic [15:0] lane_mask;
  logic [7:0]  num_acc;
  logic [4:0]  shift;
  logic [15:0] offset;
  logic        mode;
  logic        mask_ptr;
  logic        offset_ptr;

  // Commit one GPIO write per detected strobe edge; the other register's byte pointer restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_mask  <= 16'hFFFF;
      num_acc    <= 8'd1;
      shift      <= 5'd0;
      offset     <= 16'd0;
      mode       <= 1'b0;
      mask_ptr   <= 1'b0;
      offset_ptr <= 1'b0;
    end else if (w_edge) begin
      case (wr_addr)
        ADDR_LANE_MASK: begin
          if (!mask_ptr) lane_mask[7:0]  <= wr_data;
          else           lane_mask[15:8] <= wr_data;
          mask_ptr   <= ~mask_ptr;
          offset_ptr <= 1'b0;
        end
        ADDR_OFFSET: begin
          if (!offset_ptr) offset[7:0]  <= wr_data;
          else             offset[15:8] <= wr_data;
          offset_ptr <= ~offset_ptr;
          mask_ptr   <= 1'b0;
        end
        ADDR_NUM_ACC: begin
          num_acc    <= wr_data;
          mask_ptr   <= 1'b0;
          offset_ptr <= 1'b0;
        end
        ADDR_SHIFT: begin
          shift      <= wr_data[4:0];
          mask_ptr   <= 1'b0;
          offset_ptr <= 1'b0;
        end
        ADDR_MODE: begin
          mode       <= wr_data[0];
          mask_ptr   <= 1'b0;
          offset_ptr <= 1'b0;
        end
        default: begin
          mask_ptr   <= 1'b0;
          offset_ptr <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Window control
  // ---------------------------------------------------------------------------------------------
  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] sh_mask;
  logic [7:0]  sh_num_acc;
  logic [4:0]  sh_shift;
  logic [15:0] sh_offset;
  logic [7:0]  num_acc_eff;
  logic        take;
  logic        word_first;
  logic        word_last;

  assign num_acc_eff = (num_acc == 8'd0) ? 8'd1 : num_acc;
  assign take        = (state == ACCUM) && adc_valid;
  assign word_first  = (cnt == 8'd0);
  assign word_last   = (cnt == sh_num_acc - 8'd1);

  // Window FSM: latches the config shadow at window start; free-run re-arms on the last word so
  // back-to-back windows lose no words, triggered mode returns to IDLE and waits for del_trig.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      sh_mask    <= 16'hFFFF;
      sh_num_acc <= 8'd1;
      sh_shift   <= 5'd0;
      sh_offset  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!mode || del_trig) begin
            state      <= ACCUM;
            cnt        <= 8'd0;
            sh_mask    <= lane_mask;
            sh_num_acc <= num_acc_eff;
            sh_shift   <= shift;
            sh_offset  <= offset;
          end
        end
        ACCUM: begin
          if (adc_valid) begin
            if (word_last) begin
              cnt <= 8'd0;
              if (!mode) begin
                sh_mask    <= lane_mask;
                sh_num_acc <= num_acc_eff;
                sh_shift   <= shift;
                sh_offset  <= offset;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath pipeline
  // ---------------------------------------------------------------------------------------------
  logic [19:0] lane_sum_c;

  // Sum of enabled lanes; 16 x 16b signed needs 20 bits.
  always_comb begin
    lane_sum_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (sh_mask[i]) begin
        lane_sum_c = lane_sum_c + {{4{adc_in[16*i+15]}}, adc_in[16*i +: 16]};
      end
    end
  end

  logic        s1_valid;
  logic        s1_first;
  logic        s1_last;
  logic [19:0] s1_sum;
  logic [15:0] s1_offset;
  logic [4:0]  s1_shift;

  // Stage 1: register the lane sum together with its window position and the window's
  // offset/shift, since the shadow may already belong to the next window by stage 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      s1_offset <= '0;
      s1_shift  <= '0;
    end else begin
      s1_valid  <= take;
      s1_first  <= word_first;
      s1_last   <= word_last;
      s1_sum    <= lane_sum_c;
      s1_offset <= sh_offset;
      s1_shift  <= sh_shift;
    end
  end

  logic        s2_valid;
  logic [31:0] acc;
  logic [15:0] s2_offset;
  logic [4:0]  s2_shift;

  // Stage 2: accumulate over the window; s2_valid marks a completed window sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      acc       <= '0;
      s2_offset <= '0;
      s2_shift  <= '0;
    end else begin
      s2_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc       <= s1_first ? {{12{s1_sum[19]}}, s1_sum}
                              : acc + {{12{s1_sum[19]}}, s1_sum};
        s2_offset <= s1_offset;
        s2_shift  <= s1_shift;
      end
    end
  end

  logic signed [31:0] diff_c;
  logic signed [31:0] shifted_c;
  logic [NUM_BITS-1:0] result_c;

  // Offset removal, arithmetic shift and saturation to the signed output range.
  always_comb begin
    diff_c    = $signed(acc - {{16{s2_offset[15]}}, s2_offset});
    shifted_c = diff_c >>> s2_shift;
    if (shifted_c > SAT_MAX)      result_c = SAT_MAX[NUM_BITS-1:0];
    else if (shifted_c < SAT_MIN) result_c = SAT_MIN[NUM_BITS-1:0];
    else                          result_c = shifted_c[NUM_BITS-1:0];
  end

  // Stage 3: registered result and its single-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_val_out   <= '0;
      fsm_out_valid <= 1'b0;
    end else begin
      fsm_out_valid <= s2_valid;
      if (s2_valid) fsm_val_out <= result_c;
    end
  end

endmodule
